// File: rtl/tw_rom3_reload_seq_pkg.sv
// tw_pkg: shared constants and types for the stage-0 twiddle ROM reload sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   GOLDILOCKS_P  field modulus used by the optional range fold on accepted words
//   rom3_w_e      encoding of the ROM's ROM3_w write-select port
//   state_e       reload FSM states
package tw_pkg;

  localparam logic [63:0] GOLDILOCKS_P = 64'hFFFF_FFFF_0000_0001;

  // ROM3_w codes; 2'd3 is never driven.
  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_HI   = 2'd1,
    W_LO   = 2'd2
  } rom3_w_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_WAIT_HI  = 3'd2,
    S_BURST_HI = 3'd3,
    S_GAP      = 3'd4,
    S_BURST_LO = 3'd5,
    S_DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/tw_rom3_reload_seq_if.sv
// Bundle of the reload sequencer's control, upstream stream and ROM write-port signals.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the upstream word stream; rom_busy holds bursts off.
//
// Signals:
//   load_start, load_abort          control pulses into the sequencer
//   in_valid, in_data, in_ready     upstream valid/ready word stream
//   rom_busy                        stage-0 ROM read activity
//   ROM3_w, horizontal_data_out     ROM write port
//   busy, done, range_err           status
// Modports: master = the side that drives control/stream/rom_busy, slave = the sequencer.
interface tw_rom3_reload_seq_if #(
  parameter int DW = 64
);

  logic          load_start;
  logic          load_abort;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          rom_busy;
  logic [1:0]    ROM3_w;
  logic [DW-1:0] horizontal_data_out;
  logic          busy;
  logic          done;
  logic          range_err;

  modport master (
    output load_start, load_abort, in_valid, in_data, rom_busy,
    input  in_ready, ROM3_w, horizontal_data_out, busy, done, range_err
  );

  modport slave (
    input  load_start, load_abort, in_valid, in_data, rom_busy,
    output in_ready, ROM3_w, horizontal_data_out, busy, done, range_err
  );

endinterface

// File: rtl/tw_rom3_reload_seq_buf.sv
// tw_halfword_buf: 2*ENTRIES x DW half-word register file for one reload.
// Latency: write lands at the clock edge; read is combinational from {beat, hi/lo}.
// Backpressure: none; the writer only asserts i_we for accepted words.
//
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset (pointer only)
//   i_clr                clears the write pointer; wins over i_we
//   i_we, i_wdata        store i_wdata at the write pointer, then advance it
//   i_rd_beat, i_rd_lo   read index {beat, lo}: lo=0 selects e[beat].hi, lo=1 e[beat].lo
//   o_rdata              addressed half-word
//   o_wptr               current write pointer (number of words stored, modulo depth)
module tw_halfword_buf #(
  parameter int DW      = 64,
  parameter int ENTRIES = 4,
  parameter int CNT_W   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [DW-1:0]    i_wdata,
  input  logic [CNT_W-2:0] i_rd_beat,
  input  logic             i_rd_lo,
  output logic [DW-1:0]    o_rdata,
  output logic [CNT_W-1:0] o_wptr
);

  localparam int               DEPTH    = 2 * ENTRIES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [CNT_W-1:0] r_wptr;
  logic [CNT_W-1:0] w_rd_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
    end else if (i_we) begin
      r_wptr <= (r_wptr == LAST_IDX) ? '0 : r_wptr + 1'b1;
    end
  end

  // Contents need no reset: every entry is rewritten before it is replayed.
  always_ff @(posedge i_clk) begin
    if (i_we && !i_clr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Words arrive as e0.hi, e0.lo, e1.hi, ... so entry k lives at {k, lo}.
  assign w_rd_idx = {i_rd_beat, i_rd_lo};
  assign o_rdata  = r_mem[w_rd_idx];
  assign o_wptr   = r_wptr;

endmodule

// File: rtl/tw_rom3_reload_seq.sv
// tw_rom3_reload_seq: collects 2*ENTRIES twiddle half-words, replays them as a HI burst then a LO burst.
// Latency: last word accepted in cycle t -> first HI beat at t+2, done at t+2+2*ENTRIES+1 (rom_busy low).
// Backpressure: in_ready only while collecting; rom_busy holds WAIT_HI and GAP, never an open burst.
//
// Ports:
//   CLK     clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     tw_rom3_reload_seq_if.slave: load_start/load_abort, in_valid/in_data/in_ready,
//           rom_busy, ROM3_w/horizontal_data_out, busy, done, range_err
// Build option: TW_RANGE_CHK_EN folds accepted words >= GOLDILOCKS_P by subtracting P and
// raises the sticky range_err; without it words are stored as-is and range_err is 0.
module tw_rom3_reload_seq
  import tw_pkg::*;
#(
  parameter int DW      = 64,
  parameter int ENTRIES = 4,
  parameter int CNT_W   = 3
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  tw_rom3_reload_seq_if.slave   bus
);

  localparam int                BEAT_W    = CNT_W - 1;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(2 * ENTRIES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ENTRIES - 1);

  state_e            r_state;
  state_e            w_nxt_state;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_nxt_beat;

  rom3_w_e           r_rom3_w;
  rom3_w_e           w_nxt_rom3_w;
  logic [DW-1:0]     r_hdata;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_we;
  logic              w_clr;
  logic              w_start_ok;
  logic              w_rd_lo;
  logic              w_burst;
  logic [DW-1:0]     w_wdata;
  logic [DW-1:0]     w_rdata;
  logic [CNT_W-1:0]  w_wptr;

  // r_in_ready is high exactly while in COLLECT, so this is the upstream transfer.
  assign w_accept   = r_in_ready & bus.in_valid;
  // A word arriving alongside an abort is dropped together with the rest of the load.
  assign w_we       = w_accept & ~bus.load_abort;
  assign w_start_ok = (r_state == S_IDLE) & bus.load_start & ~bus.load_abort;
  assign w_clr      = bus.load_abort | w_start_ok;

  // ---------------------------------------------------------------------------
  // Optional range fold in the accept path (pure combinational, no added stage)
  // ---------------------------------------------------------------------------
`ifdef TW_RANGE_CHK_EN
  localparam logic [DW-1:0] P_DW = DW'(GOLDILOCKS_P);

  logic w_over;
  logic r_range_err;

  assign w_over  = (bus.in_data >= P_DW);
  assign w_wdata = w_over ? (bus.in_data - P_DW) : bus.in_data;

  // Sticky until the next honoured load_start.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_range_err <= 1'b0;
    end else if (w_start_ok) begin
      r_range_err <= 1'b0;
    end else if (w_we && w_over) begin
      r_range_err <= 1'b1;
    end
  end

  assign bus.range_err = r_range_err;
`else
  assign w_wdata       = bus.in_data;
  assign bus.range_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Half-word buffer
  // ---------------------------------------------------------------------------
  tw_halfword_buf #(
    .DW      (DW),
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) u_buf (
    .i_clk     (CLK),
    .i_rst_n   (rst_n),
    .i_clr     (w_clr),
    .i_we      (w_we),
    .i_wdata   (w_wdata),
    .i_rd_beat (w_nxt_beat),
    .i_rd_lo   (w_rd_lo),
    .o_rdata   (w_rdata),
    .o_wptr    (w_wptr)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_beat  <= w_nxt_beat;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, beat counter and next output values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_beat  = r_beat;

    case (r_state)
      S_IDLE: begin
        if (bus.load_start) w_nxt_state = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_accept && (w_wptr == LAST_WORD)) w_nxt_state = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        w_nxt_beat = '0;
        if (!bus.rom_busy) w_nxt_state = S_BURST_HI;
      end
      // Bursts ignore rom_busy: once started they run to the last beat.
      S_BURST_HI: begin
        if (r_beat == LAST_BEAT) begin
          w_nxt_state = S_GAP;
          w_nxt_beat  = '0;
        end else begin
          w_nxt_beat = r_beat + 1'b1;
        end
      end
      // One idle write beat so the ROM's row counter is back at 0 for the LO burst.
      S_GAP: begin
        w_nxt_beat = '0;
        if (!bus.rom_busy) w_nxt_state = S_BURST_LO;
      end
      S_BURST_LO: begin
        if (r_beat == LAST_BEAT) begin
          w_nxt_state = S_DONE;
          w_nxt_beat  = '0;
        end else begin
          w_nxt_beat = r_beat + 1'b1;
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_beat  = '0;
      end
    endcase

    if (bus.load_abort) begin
      w_nxt_state = S_IDLE;
      w_nxt_beat  = '0;
    end
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    w_nxt_rom3_w = W_NONE;
    w_burst      = 1'b0;
    w_rd_lo      = 1'b0;
    case (w_nxt_state)
      S_BURST_HI: begin
        w_nxt_rom3_w = W_HI;
        w_burst      = 1'b1;
      end
      S_BURST_LO: begin
        w_nxt_rom3_w = W_LO;
        w_burst      = 1'b1;
        w_rd_lo      = 1'b1;
      end
      default: begin
        w_nxt_rom3_w = W_NONE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_rom3_w   <= W_NONE;
      r_hdata    <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rom3_w   <= w_nxt_rom3_w;
      r_hdata    <= w_burst ? w_rdata : '0;
      r_in_ready <= (w_nxt_state == S_COLLECT);
      r_busy     <= (w_nxt_state != S_IDLE);
      r_done     <= (w_nxt_state == S_DONE);
    end
  end

  assign bus.ROM3_w              = r_rom3_w;
  assign bus.horizontal_data_out = r_hdata;
  assign bus.in_ready            = r_in_ready;
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;

endmodule

// File: tb/tb_tw_rom3_reload_seq.sv
// Bench for tw_rom3_reload_seq: table vectors, hand sequences (abort, ignored starts), random loads.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_tw_rom3_reload_seq;

  localparam logic [63:0] P    = 64'hFFFF_FFFF_0000_0001;
  localparam int          MAXC = 120;

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  tw_rom3_reload_seq_if #(.DW(64)) bus();

  tw_rom3_reload_seq #(
    .DW      (64),
    .ENTRIES (4),
    .CNT_W   (3)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference store rule: what a word must look like when replayed to the ROM.
  function automatic logic [63:0] ref_store(input logic [63:0] w);
`ifdef TW_RANGE_CHK_EN
    return (w >= P) ? (w - P) : w;
`else
    return w;
`endif
  endfunction

  function automatic logic ref_rerr(input logic [63:0] w);
`ifdef TW_RANGE_CHK_EN
    return (w >= P);
`else
    return 1'b0;
`endif
  endfunction

  typedef struct packed {
    logic [7:0][63:0] w;
    logic [1:0]       throttle;
    logic [3:0]       s_hi;
    logic [3:0]       s_gap;
    logic [3:0][63:0] hi;
    logic [3:0][63:0] lo;
    logic             rerr;
  } vec_t;

  vec_t vecs [3];

  // Per-load observation record.
  logic [63:0] cur_w [8];
  logic [1:0]  log_w    [MAXC];
  logic        log_busy [MAXC];
  logic        log_rerr [MAXC];
  logic [65:0] beat_q [$];
  int acc_tot, L, hi_cyc, lo_cyc, done_cnt, done_cyc, viol;

  // Drives one load starting with load_start in cycle 0. Stalls are placed relative to the
  // cycle L of the last accept: rom_busy=1 for s_hi cycles in WAIT_HI and s_gap in GAP.
  task automatic run_load(input int throttle, input int s_hi, input int s_gap,
                          input int ab_rel, input int xs_abs, input int xs_rel);
    logic prev_busy;
    logic [1:0] prev_w;
    bit stop;
    beat_q.delete();
    acc_tot = 0; L = -1; hi_cyc = -1; lo_cyc = -1;
    done_cnt = 0; done_cyc = -1; viol = 0;
    prev_busy = 1'b0; prev_w = 2'd0; stop = 1'b0;
    for (int c = 0; c < MAXC && !stop; c++) begin
      @(posedge CLK); #1;
      bus.load_start = (c == 0) || (c == xs_abs) || (L >= 0 && xs_rel >= 0 && c == L + xs_rel);
      bus.load_abort = (L >= 0 && ab_rel >= 0 && c == L + ab_rel);
      if (acc_tot < 8) begin
        case (throttle)
          0:       bus.in_valid = 1'b1;
          1:       bus.in_valid = ((c % 2) == 1);
          default: bus.in_valid = 1'($urandom_range(0, 1));
        endcase
        bus.in_data = cur_w[acc_tot];
      end else begin
        // Keep offering junk after the eighth word: it must never be taken.
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hBAD0_0000_0000_0BAD;
      end
      if (L < 0) bus.rom_busy = 1'($urandom_range(0, 1));
      else bus.rom_busy = (c >= L + 1 && c <= L + s_hi) ||
                          (c >= L + s_hi + 6 && c <= L + s_hi + 5 + s_gap);
      @(negedge CLK);
      log_w[c]    = bus.ROM3_w;
      log_busy[c] = bus.busy;
      log_rerr[c] = bus.range_err;
      if (bus.ROM3_w != 2'd0) begin
        beat_q.push_back({bus.ROM3_w, bus.horizontal_data_out});
        if (bus.ROM3_w == 2'd1 && hi_cyc < 0) hi_cyc = c;
        if (bus.ROM3_w == 2'd2 && lo_cyc < 0) lo_cyc = c;
        if (prev_w == 2'd0 && prev_busy) viol++;
        if (bus.ROM3_w == 2'd3) viol++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_tot++;
        if (acc_tot == 8) L = c;
      end
      prev_w    = bus.ROM3_w;
      prev_busy = bus.rom_busy;
      if (done_cyc >= 0 && c >= done_cyc + 3) stop = 1'b1;
      if (ab_rel >= 0 && L >= 0 && c >= L + ab_rel + 4) stop = 1'b1;
    end
    @(posedge CLK); #1;
    bus.load_start = 1'b0; bus.load_abort = 1'b0;
    bus.in_valid   = 1'b0; bus.rom_busy   = 1'b0;
    @(negedge CLK);
  endtask

  task automatic verify(input string name, input int s_hi, input int s_gap,
                        input logic [3:0][63:0] eh, input logic [3:0][63:0] el,
                        input logic err);
    check({name, " accepts"}, 64'(acc_tot), 64'd8);
    check({name, " beats"}, 64'(beat_q.size()), 64'd8);
    for (int k = 0; k < 4; k++) begin
      if (beat_q.size() == 8) begin
        check($sformatf("%s hi%0d code", name, k), 64'(beat_q[k][65:64]), 64'd1);
        check($sformatf("%s hi%0d data", name, k), beat_q[k][63:0], eh[k]);
        check($sformatf("%s lo%0d code", name, k), 64'(beat_q[4+k][65:64]), 64'd2);
        check($sformatf("%s lo%0d data", name, k), beat_q[4+k][63:0], el[k]);
      end
    end
    check({name, " first hi cycle"}, 64'(hi_cyc), 64'(L + s_hi + 2));
    check({name, " first lo cycle"}, 64'(lo_cyc), 64'(L + s_hi + s_gap + 7));
    check({name, " done count"}, 64'(done_cnt), 64'd1);
    check({name, " done cycle"}, 64'(done_cyc), 64'(L + s_hi + s_gap + 11));
    check({name, " write while busy"}, 64'(viol), 64'd0);
    check({name, " range_err"}, 64'(bus.range_err), 64'(err));
    check({name, " idle after"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic model_verify(input string name, input int s_hi, input int s_gap);
    logic [3:0][63:0] eh, el;
    logic e;
    e = 1'b0;
    for (int k = 0; k < 4; k++) begin
      eh[k] = ref_store(cur_w[2*k]);
      el[k] = ref_store(cur_w[2*k+1]);
    end
    for (int i = 0; i < 8; i++) e = e | ref_rerr(cur_w[i]);
    verify(name, s_hi, s_gap, eh, el, e);
  endtask

  initial begin
    // ---- vector table ----
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 8; i++) vecs[v].w[i] = 64'h11 + 64'(i);
      for (int k = 0; k < 4; k++) begin
        vecs[v].hi[k] = 64'h11 + 64'(2*k);
        vecs[v].lo[k] = 64'h12 + 64'(2*k);
      end
      vecs[v].rerr = 1'b0;
    end
    vecs[0].throttle = 2'd0; vecs[0].s_hi = 4'd0; vecs[0].s_gap = 4'd0;
    vecs[1].throttle = 2'd1; vecs[1].s_hi = 4'd5; vecs[1].s_gap = 4'd3;

    vecs[2].w[0] = 64'hFFFF_FFFF_0000_0005;
    vecs[2].w[1] = 64'hFFFF_FFFF_0000_0001;
    vecs[2].w[2] = 64'hFFFF_FFFF_0000_0000;
    vecs[2].w[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs[2].w[4] = 64'h0; vecs[2].w[5] = 64'h1;
    vecs[2].w[6] = 64'h2; vecs[2].w[7] = 64'h3;
    vecs[2].throttle = 2'd2; vecs[2].s_hi = 4'd1; vecs[2].s_gap = 4'd0;
`ifdef TW_RANGE_CHK_EN
    vecs[2].hi[0] = 64'h4;
    vecs[2].hi[1] = 64'hFFFF_FFFF_0000_0000;
    vecs[2].lo[0] = 64'h0;
    vecs[2].lo[1] = 64'h0000_0000_FFFF_FFFE;
    vecs[2].rerr  = 1'b1;
`else
    vecs[2].hi[0] = 64'hFFFF_FFFF_0000_0005;
    vecs[2].hi[1] = 64'hFFFF_FFFF_0000_0000;
    vecs[2].lo[0] = 64'hFFFF_FFFF_0000_0001;
    vecs[2].lo[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs[2].rerr  = 1'b0;
`endif
    vecs[2].hi[2] = 64'h0; vecs[2].hi[3] = 64'h2;
    vecs[2].lo[2] = 64'h1; vecs[2].lo[3] = 64'h3;

    // ---- reset ----
    rst_n = 1'b0;
    bus.load_start = 1'b0; bus.load_abort = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 64'h55; bus.rom_busy = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset ROM3_w", 64'(bus.ROM3_w), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset data", bus.horizontal_data_out, 64'd0);
    check("reset range_err", 64'(bus.range_err), 64'd0);
    @(posedge CLK); #1;
    rst_n = 1'b1; bus.in_valid = 1'b0;
    @(negedge CLK);

    // ---- table-driven loads ----
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 8; i++) cur_w[i] = vecs[v].w[i];
      run_load(int'(vecs[v].throttle), int'(vecs[v].s_hi), int'(vecs[v].s_gap), -1, -1, -1);
      verify($sformatf("vec%0d", v), int'(vecs[v].s_hi), int'(vecs[v].s_gap),
             vecs[v].hi, vecs[v].lo, vecs[v].rerr);
    end

    // ---- abort at HI beat 2; its load_start also clears any sticky range_err ----
    for (int i = 0; i < 8; i++) cur_w[i] = 64'h21 + 64'(i);
    run_load(0, 0, 0, 4, -1, -1);
    check("abort accepts", 64'(acc_tot), 64'd8);
    check("abort range_err cleared", 64'(log_rerr[1]), 64'd0);
    if (L >= 0 && L + 5 < MAXC) begin
      check("abort beat2 present", 64'(log_w[L+4]), 64'd1);
      check("abort ROM3_w next", 64'(log_w[L+5]), 64'd0);
      check("abort busy next", 64'(log_busy[L+5]), 64'd0);
    end
    check("abort beats written", 64'(beat_q.size()), 64'd3);
    check("abort no done", 64'(done_cnt), 64'd0);

    for (int i = 0; i < 8; i++) cur_w[i] = 64'h31 + 64'(i);
    run_load(0, 0, 0, -1, -1, -1);
    model_verify("reload after abort", 0, 0);

    // ---- load_start pulses in COLLECT and BURST_LO are ignored ----
    for (int i = 0; i < 8; i++) cur_w[i] = 64'h41 + 64'(i);
    run_load(0, 0, 0, -1, 3, 8);
    model_verify("ignored start", 0, 0);

    // ---- randomized loads against the reference rule ----
    for (int r = 0; r < 12; r++) begin
      int sh, sg;
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0:       cur_w[i] = {$urandom, $urandom};
          1:       cur_w[i] = P + 64'($urandom_range(0, 15));
          2:       cur_w[i] = P - 64'd1 - 64'($urandom_range(0, 3));
          default: cur_w[i] = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
        endcase
      end
      sh = int'($urandom_range(0, 4));
      sg = int'($urandom_range(0, 3));
      run_load(2, sh, sg, -1, -1, -1);
      model_verify($sformatf("rand%0d", r), sh, sg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
